sensor_event_gen: RTL and testbench
===================================

// Module: sensor_event_gen
// PURPOSE
//  Downstream consumer of the debounced sensor/button level (active-high, already filtered).
//  Classifies each activation into PRESS, SHORT, LONG and REPEAT events for the mode controller.
//  Presents events through a one-entry valid/ready holding register.
//  Flags lost events with a sticky overrun bit.
// PARAMETERS
//  TICK_DIV      4   clk cycles per internal tick (board value 50000)
//  LONG_TICKS    5   ticks held before LONG is emitted (>=1)
//  REPEAT_TICKS  3   ticks between REPEAT events while still held after LONG (>=1)
// PORTS
//  clk          in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high
//  sensor_db    in   1  debounced level; 1 = active. Is 1 during reset and just after it.
//  evt_valid    out  1  event pending in holding register
//  evt_code     out  2  0=PRESS 1=SHORT 2=LONG 3=REPEAT; meaningful only while evt_valid=1
//  evt_ready    in   1  consumer accepts when evt_valid&&evt_ready at posedge
//  held         out  1  1 while FSM is in HELD or LONG_HELD
//  evt_overrun  out  1  sticky; set when an event is dropped, cleared only by reset
// BEHAVIOUR
//  Reset values: evt_valid=0, evt_code=0, held=0, evt_overrun=0, state=WAIT_LOW, all counters 0.
//  Reset has priority at every edge; it aborts any hold in progress and drops any pending event.
//  FSM, sampled at posedge; release (sensor_db=0) takes priority over a tick in the same cycle:
//   WAIT_LOW : sensor_db=0 -> IDLE. No event. Blocks the spurious PRESS caused by the debouncer
//              output sitting high after reset.
//   IDLE     : sensor_db=1 -> HELD; emit PRESS; clear prescaler and hold_cnt.
//   HELD     : sensor_db=0 -> IDLE; emit SHORT.
//              On tick: hold_cnt++. The tick that brings hold_cnt to LONG_TICKS
//              -> LONG_HELD; emit LONG; clear rep_cnt.
//   LONG_HELD: sensor_db=0 -> IDLE; no event.
//              On tick: rep_cnt++. At REPEAT_TICKS: emit REPEAT; rep_cnt=0.
//  Prescaler: counts 0..TICK_DIV-1 and ticks at TICK_DIV-1; cleared on entry to HELD.
//   If sensor_db first samples 1 at edge k, PRESS appears on evt_valid after edge k (latency 1 clk).
//   LONG is loaded at edge k+LONG_TICKS*TICK_DIV.
//   Each REPEAT follows the previous LONG/REPEAT by REPEAT_TICKS*TICK_DIV clks.
//  Widths: hold_cnt $clog2(LONG_TICKS+1); rep_cnt $clog2(REPEAT_TICKS+1); neither wraps.
//  Holding register update, per edge:
//   - new event and (!evt_valid or evt_ready): load code, evt_valid=1 (same-cycle ack+load legal).
//   - new event while evt_valid && !evt_ready: keep old event, drop new, set evt_overrun.
//   - no new event and evt_ready: evt_valid=0.
//   - evt_code is held stable while evt_valid=1 and !evt_ready.
//  At most one new event per cycle by construction.
//  A sensor_db glitch lasting 1 clk from IDLE yields PRESS, then SHORT.
// STRUCTURE
//  sensor_evt_defs.vh (shared include): EVT_PRESS/SHORT/LONG/REPEAT codes, state encodings.
//  Sub-module tick_prescaler #(TICK_DIV) (clk, reset, clear, tick): reusable by other timed blocks.
//  Top: FSM, hold_cnt/rep_cnt, event holding register, overrun flag.
// TESTING (defaults TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=3, evt_ready=1 unless stated)
//  1. Reset with sensor_db=1 held for 30 clks -> no event, held=0.
//     Then sensor_db 0 for 2 clks, then 1 -> PRESS valid 1 clk after the rise.
//  2. From IDLE, sensor_db=1 for 8 clks then 0 -> PRESS, then SHORT 1 clk after the fall.
//     No LONG; held goes 0.
//  3. sensor_db=1 for 50 clks -> PRESS at k; LONG at k+20; REPEAT at k+32 and k+44.
//     Release -> no event.
//  4. evt_ready=0, press and release -> PRESS held with stable code; SHORT dropped; evt_overrun=1.
//     Then raise evt_ready -> PRESS accepted; evt_overrun stays 1 until reset.
//  5. Release on the exact cycle of the 5th tick -> SHORT, not LONG.
//     Ack and new event in the same cycle -> new event loaded, no overrun.
//  6. Reset asserted at k+10 of a hold -> all outputs return to reset values.
//     No event until a 0 -> 1 sequence on sensor_db.

Source files
------------

// File: rtl/sensor_event_gen_pkg.sv
// rtl/sensor_event_gen_pkg.sv - event codes and FSM state encodings for sensor_event_gen
package sensor_event_gen_pkg;

   typedef enum logic [1:0] {
      EVT_PRESS  = 2'd0,
      EVT_SHORT  = 2'd1,
      EVT_LONG   = 2'd2,
      EVT_REPEAT = 2'd3
   } evt_code_t;

   typedef enum logic [1:0] {
      ST_WAIT_LOW  = 2'd0,
      ST_IDLE      = 2'd1,
      ST_HELD      = 2'd2,
      ST_LONG_HELD = 2'd3
   } state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val > 1) ? $clog2(max_val) : 1;
   endfunction

endpackage

// File: rtl/sensor_event_gen_if.sv
// rtl/sensor_event_gen_if.sv - valid/ready event channel between sensor_event_gen and its consumer
interface sensor_event_gen_if;

   logic       evt_valid;
   logic [1:0] evt_code;
   logic       evt_ready;

   modport master (output evt_valid, output evt_code, input evt_ready);
   modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/sensor_event_gen_tick_prescaler.sv
// rtl/sensor_event_gen_tick_prescaler.sv - free-running tick divider with synchronous clear
module tick_prescaler
   import sensor_event_gen_pkg::*;
#(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/sensor_event_gen.sv
// rtl/sensor_event_gen.sv - classifies debounced sensor activations into PRESS/SHORT/LONG/REPEAT events
module sensor_event_gen
   import sensor_event_gen_pkg::*;
#(
   parameter int TICK_DIV     = 4,
   parameter int LONG_TICKS   = 5,
   parameter int REPEAT_TICKS = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sensor_db,
   sensor_event_gen_if.master   evt,
   output logic                 held,
   output logic                 evt_overrun
);

   localparam int            HW        = cnt_width(LONG_TICKS + 1);
   localparam int            RW        = cnt_width(REPEAT_TICKS + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_TICKS - 1);

   state_t        state, state_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [RW-1:0] rep_cnt, rep_n;
   logic          tick;
   logic          presc_clear;
   logic          new_evt;
   evt_code_t     new_code;
   logic          evt_valid_q;
   logic [1:0]    evt_code_q;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk   (clk),
      .reset (reset),
      .clear (presc_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_WAIT_LOW;
         hold_cnt <= '0;
         rep_cnt  <= '0;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_n;
         rep_cnt  <= rep_n;
      end
   end

   // A release is checked before the tick so a same-cycle release always wins.
   always_comb begin
      state_n     = state;
      hold_n      = hold_cnt;
      rep_n       = rep_cnt;
      new_evt     = 1'b0;
      new_code    = EVT_PRESS;
      presc_clear = 1'b0;
      case (state)
         ST_WAIT_LOW: begin
            if (!sensor_db) state_n = ST_IDLE;
         end
         ST_IDLE: begin
            if (sensor_db) begin
               state_n     = ST_HELD;
               new_evt     = 1'b1;
               new_code    = EVT_PRESS;
               presc_clear = 1'b1;
               hold_n      = '0;
            end
         end
         ST_HELD: begin
            if (!sensor_db) begin
               state_n  = ST_IDLE;
               new_evt  = 1'b1;
               new_code = EVT_SHORT;
            end else if (tick) begin
               hold_n = hold_cnt + HW'(1);
               if (hold_cnt == HOLD_LAST) begin
                  state_n  = ST_LONG_HELD;
                  new_evt  = 1'b1;
                  new_code = EVT_LONG;
                  rep_n    = '0;
               end
            end
         end
         ST_LONG_HELD: begin
            if (!sensor_db) begin
               state_n = ST_IDLE;
            end else if (tick) begin
               if (rep_cnt == REP_LAST) begin
                  new_evt  = 1'b1;
                  new_code = EVT_REPEAT;
                  rep_n    = '0;
               end else begin
                  rep_n = rep_cnt + RW'(1);
               end
            end
         end
         default: state_n = ST_WAIT_LOW;
      endcase
   end

   // One-entry holding register: an event arriving while the slot is stuck is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt_valid_q <= 1'b0;
         evt_code_q  <= 2'd0;
         evt_overrun <= 1'b0;
      end else if (new_evt) begin
         if (!evt_valid_q || evt.evt_ready) begin
            evt_valid_q <= 1'b1;
            evt_code_q  <= new_code;
         end else begin
            evt_overrun <= 1'b1;
         end
      end else if (evt.evt_ready) begin
         evt_valid_q <= 1'b0;
      end
   end

   assign evt.evt_valid = evt_valid_q;
   assign evt.evt_code  = evt_code_q;
   assign held          = (state == ST_HELD) || (state == ST_LONG_HELD);

endmodule

// File: tb/tb_sensor_event_gen.sv
// tb/tb_sensor_event_gen.sv - self-checking bench for sensor_event_gen
module tb_sensor_event_gen;

   localparam int TICK_DIV     = 4;
   localparam int LONG_TICKS   = 5;
   localparam int REPEAT_TICKS = 3;

   logic clk;
   logic reset;
   logic sensor_db;
   logic held;
   logic evt_overrun;

   sensor_event_gen_if evt_if ();

   sensor_event_gen #(
      .TICK_DIV     (TICK_DIV),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sensor_db   (sensor_db),
      .evt         (evt_if.master),
      .held        (held),
      .evt_overrun (evt_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
      end
   endtask

   // Model: classifies by elapsed clocks since the press, not by ticks or counters.
   bit armed, active, is_long, started;
   int t;
   bit m_valid, m_ovr, have;
   int m_code, code;

   always @(posedge clk) begin
      have = 1'b0;
      code = 0;
      if (reset) begin
         armed = 0; active = 0; is_long = 0; t = 0;
         m_valid = 0; m_code = 0; m_ovr = 0;
      end else begin
         if (!armed) begin
            if (!sensor_db) armed = 1;
         end else if (!active) begin
            if (sensor_db) begin
               active = 1; t = 0; is_long = 0; have = 1; code = 0;
            end
         end else if (!sensor_db) begin
            active = 0;
            if (!is_long) begin have = 1; code = 1; end
         end else begin
            t++;
            if (!is_long && t == LONG_TICKS * TICK_DIV) begin
               is_long = 1; have = 1; code = 2;
            end else if (is_long &&
                         ((t - LONG_TICKS * TICK_DIV) % (REPEAT_TICKS * TICK_DIV)) == 0) begin
               have = 1; code = 3;
            end
         end
         if (have) begin
            if (!m_valid || evt_if.evt_ready) begin
               m_valid = 1; m_code = code;
            end else begin
               m_ovr = 1;
            end
         end else if (evt_if.evt_ready) begin
            m_valid = 0;
         end
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cyc_valid", int'(evt_if.evt_valid), int'(m_valid));
         chk("cyc_held", int'(held), int'(active));
         chk("cyc_overrun", int'(evt_overrun), int'(m_ovr));
         if (m_valid) chk("cyc_code", int'(evt_if.evt_code), m_code);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      sensor_db = 1'b1;
      evt_if.evt_ready = 1'b1;

      // 1: no spurious PRESS after reset, then a clean rise
      step(3);
      reset = 1'b0;
      step(30);
      chk("t1_no_evt", int'(evt_if.evt_valid), 0);
      chk("t1_held0", int'(held), 0);
      sensor_db = 1'b0; step(2);
      sensor_db = 1'b1; step(1);
      chk("t1_press_v", int'(evt_if.evt_valid), 1);
      chk("t1_press_c", int'(evt_if.evt_code), 0);
      chk("t1_held1", int'(held), 1);

      // 2: short hold
      sensor_db = 1'b0; step(1);
      chk("t1_short_c", int'(evt_if.evt_code), 1);
      step(3);
      sensor_db = 1'b1; step(1);
      chk("t2_press_c", int'(evt_if.evt_code), 0);
      step(7);
      sensor_db = 1'b0; step(1);
      chk("t2_short_v", int'(evt_if.evt_valid), 1);
      chk("t2_short_c", int'(evt_if.evt_code), 1);
      chk("t2_held0", int'(held), 0);
      step(1);
      chk("t2_drained", int'(evt_if.evt_valid), 0);

      // 3: long hold with repeats
      step(3);
      sensor_db = 1'b1; step(1);
      chk("t3_press_c", int'(evt_if.evt_code), 0);
      step(19);
      chk("t3_pre_long", int'(evt_if.evt_valid), 0);
      step(1);
      chk("t3_long_v", int'(evt_if.evt_valid), 1);
      chk("t3_long_c", int'(evt_if.evt_code), 2);
      step(11);
      chk("t3_pre_rep", int'(evt_if.evt_valid), 0);
      step(1);
      chk("t3_rep1_c", int'(evt_if.evt_code), 3);
      step(12);
      chk("t3_rep2_v", int'(evt_if.evt_valid), 1);
      chk("t3_rep2_c", int'(evt_if.evt_code), 3);
      step(5);
      sensor_db = 1'b0; step(1);
      chk("t3_rel_v", int'(evt_if.evt_valid), 0);
      chk("t3_rel_held", int'(held), 0);

      // 4: stalled consumer loses SHORT
      step(2);
      evt_if.evt_ready = 1'b0;
      sensor_db = 1'b1; step(1);
      chk("t4_press_c", int'(evt_if.evt_code), 0);
      sensor_db = 1'b0; step(1);
      chk("t4_ovr", int'(evt_overrun), 1);
      step(2);
      chk("t4_stable_v", int'(evt_if.evt_valid), 1);
      chk("t4_stable_c", int'(evt_if.evt_code), 0);
      evt_if.evt_ready = 1'b1; step(1);
      chk("t4_acked", int'(evt_if.evt_valid), 0);
      chk("t4_ovr_sticky", int'(evt_overrun), 1);
      step(2);

      // 5a: release on the 5th tick edge
      sensor_db = 1'b1; step(20);
      sensor_db = 1'b0; step(1);
      chk("t5_short_c", int'(evt_if.evt_code), 1);
      step(2);
      reset = 1'b1; step(2);
      reset = 1'b0; step(2);
      chk("t5_ovr_clr", int'(evt_overrun), 0);

      // 5b: ack and new event on the same edge
      evt_if.evt_ready = 1'b0;
      sensor_db = 1'b1; step(1);
      chk("t5b_press_c", int'(evt_if.evt_code), 0);
      step(2);
      evt_if.evt_ready = 1'b1;
      sensor_db = 1'b0; step(1);
      chk("t5b_load_v", int'(evt_if.evt_valid), 1);
      chk("t5b_load_c", int'(evt_if.evt_code), 1);
      chk("t5b_no_ovr", int'(evt_overrun), 0);
      step(2);

      // 6: glitch into overrun, then reset mid-hold
      evt_if.evt_ready = 1'b0;
      sensor_db = 1'b1; step(1);
      sensor_db = 1'b0; step(1);
      chk("t6_ovr", int'(evt_overrun), 1);
      sensor_db = 1'b1; step(10);
      reset = 1'b1; step(1);
      chk("t6_rst_v", int'(evt_if.evt_valid), 0);
      chk("t6_rst_c", int'(evt_if.evt_code), 0);
      chk("t6_rst_held", int'(held), 0);
      chk("t6_rst_ovr", int'(evt_overrun), 0);
      reset = 1'b0;
      evt_if.evt_ready = 1'b1;
      step(20);
      chk("t6_no_evt", int'(evt_if.evt_valid), 0);
      sensor_db = 1'b0; step(2);
      sensor_db = 1'b1; step(1);
      chk("t6_press_v", int'(evt_if.evt_valid), 1);
      chk("t6_press_c", int'(evt_if.evt_code), 0);
      step(3);
      sensor_db = 1'b0; step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
